// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side unpacker and the future write-side packer.
// The ratio check is a macro so it can expand into a generate block inside each user module.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_RATIO_CHECK(IN_W, OUT_W) \
   if ((((IN_W) % (OUT_W)) != 0) || (((IN_W) / (OUT_W)) < 2) || \
       (((((IN_W) / (OUT_W)) & (((IN_W) / (OUT_W)) - 1))) != 0)) begin : g_ratio_illegal \
      $error("fifo: IN_WIDTH/OUT_WIDTH must be an integer power of two >= 2"); \
   end

package fifo_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   function automatic int idx_w(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

`endif

// File: rtl/fifo_unpacker_if.sv
// FIFO read port plus narrow beat stream; master is the unpacker, slave is the FIFO/consumer side.
interface fifo_unpacker_if #(
   parameter int IN_WIDTH  = 512,
   parameter int OUT_WIDTH = 64
);
   logic [IN_WIDTH-1:0]  fifo_q;
   logic                 fifo_empty;
   logic                 fifo_rdreq;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;

   modport master (
      input  fifo_q, fifo_empty, out_ready,
      output fifo_rdreq, out_data, out_valid, out_last
   );

   modport slave (
      output fifo_q, fifo_empty, out_ready,
      input  fifo_rdreq, out_data, out_valid, out_last
   );
endinterface

// File: rtl/fifo_unpacker.sv
// Pops wide words from a show-ahead FIFO and serialises each into RATIO beats, LSB beat first.
// The pop of the next word overlaps the last-beat transfer so words stream without bubbles.
module fifo_unpacker
   import fifo_pkg::*;
#(
   parameter int IN_WIDTH  = 512,
   parameter int OUT_WIDTH = 64
) (
   input  logic            clock,
   input  logic            reset_n,
   fifo_unpacker_if.master bus,
   output logic            busy,
   output logic [31:0]     words_done
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int IW    = idx_w(RATIO);
   localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

   `FIFO_RATIO_CHECK(IN_WIDTH, OUT_WIDTH)

   state_t              state_r;
   logic [IW-1:0]       idx_r;
   logic [IN_WIDTH-1:0] hold_r;
   logic [31:0]         words_done_r;
   logic                xfer_s;
   logic                last_s;
   logic                pop_s;

   assign xfer_s = (state_r == STREAM) && bus.out_ready;
   assign last_s = (idx_r == LAST_IDX);
   // Reset gates the pop so the FIFO never loses a word while the unpacker is held.
   assign pop_s  = reset_n && !bus.fifo_empty && ((state_r == IDLE) || (xfer_s && last_s));

   assign bus.fifo_rdreq = pop_s;
   assign bus.out_valid  = (state_r == STREAM);
   assign bus.out_last   = (state_r == STREAM) && last_s;
   assign bus.out_data   = hold_r[int'(idx_r) * OUT_WIDTH +: OUT_WIDTH];
   assign busy           = (state_r == STREAM);
   assign words_done     = words_done_r;

   // Control FSM: beat index, streaming state and completed-word counter.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         idx_r        <= {IW{1'b0}};
         words_done_r <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  state_r <= STREAM;
                  idx_r   <= {IW{1'b0}};
               end
            end
            STREAM: begin
               if (xfer_s) begin
                  if (last_s) begin
                     words_done_r <= words_done_r + 32'd1;
                     idx_r        <= {IW{1'b0}};
                     if (!pop_s) begin
                        state_r <= IDLE;
                     end
                  end else begin
                     idx_r <= idx_r + IW'(1);
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               idx_r   <= {IW{1'b0}};
            end
         endcase
      end
   end

   // Word hold register; contents are irrelevant outside STREAM so it carries no reset.
   always_ff @(posedge clock) begin
      if (pop_s) begin
         hold_r <= bus.fifo_q;
      end
   end

endmodule

// File: doc/fifo_unpacker.md
# fifo_unpacker

Read-side consumer for the design's show-ahead FIFO. It pops wide words (default 512 b) from the FIFO's q/empty/rdreq port and serialises each word into narrower beats on a valid/ready stream. Downstream compute lanes use it to take 64 b operands from wide DMA words without bubbles. It is instantiated next to the FIFO in the parent, with FIFO q/empty wired straight in.

## Interface
- IN_WIDTH, 512, FIFO word width.
- OUT_WIDTH, 64, output beat width.
- RATIO, derived as IN_WIDTH/OUT_WIDTH (beats per word).
  - Must be an integer power of two, ≥ 2.
  - Elaboration fails otherwise.
- Clock and reset: single clock `clock`; reset `reset_n` is synchronous and active-low.
- clock  in  1  sole clock; all state updates on posedge.
- reset_n  in  1  synchronous active-low reset.
- fifo_q  in  IN_WIDTH  FIFO head word; valid whenever fifo_empty=0 (show-ahead).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdreq  out  1  pop strobe; the head is consumed at the edge where this is 1.
- out_data  out  OUT_WIDTH  current beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  current beat is the final beat (index RATIO-1) of its word.
- busy  out  1  a word is held (mirrors out_valid).
- words_done  out  32  count of fully emitted words; wraps modulo 2^32.

## Operation
- State: hold register hold_q[IN_WIDTH], beat index idx[log2 RATIO], FSM {IDLE, STREAM}, words_done.
- Beat handshake: a beat transfers when out_valid && out_ready.
- Pop condition ("pop"):
  - pop = reset_n && !fifo_empty && (state==IDLE || (xfer && idx==RATIO-1)).
  - fifo_rdreq = pop, driven combinationally.
- FSM transitions:
  - IDLE → STREAM on pop: hold_q<=fifo_q, idx<=0.
  - STREAM, xfer with idx<RATIO-1: idx<=idx+1.
  - STREAM, xfer with idx==RATIO-1 and pop: reload hold_q, idx<=0, stay in STREAM, words_done+=1.
  - STREAM, xfer with idx==RATIO-1 and no pop: go to IDLE, words_done+=1.
  - STREAM, no xfer: hold all state.
- Output mapping:
  - out_data = hold_q[idx*OUT_WIDTH +: OUT_WIDTH]. Beat 0 is the LSBs, beat RATIO-1 the MSBs.
  - out_valid = busy = (state==STREAM).
  - out_last = out_valid && idx==RATIO-1.
- Stall rule: while out_valid=1 and out_ready=0, out_data, out_last and idx stay stable. A beat is never dropped, duplicated or retracted.
- Sustained throughput: one beat per cycle. No bubble between words when the FIFO stays non-empty.
- Reset (reset_n=0 at an edge):
  - state<=IDLE, idx<=0, words_done<=0. hold_q contents are don't-care.
  - fifo_rdreq is forced to 0 combinationally while reset_n=0.
  - Reset mid-word discards the remaining beats of the held word; that word is not counted.

## Timing
- Reset values: out_valid=0, out_last=0, busy=0, fifo_rdreq=0, words_done=0. out_data is don't-care.
- Latency: if fifo_empty falls in cycle N while IDLE, then fifo_rdreq=1 in cycle N and out_valid=1 from cycle N+1.
- Last-beat / reload overlap: on the last-beat transfer, fifo_rdreq and the reload happen in the same cycle, so beat 0 of the next word is presented in the following cycle.
- fifo_rdreq is never asserted while fifo_empty=1. Underflow is impossible by construction.
- out_ready may change every cycle; it has no combinational path to out_valid.
- out_ready does reach fifo_rdreq combinationally. The FIFO tolerates this because its rdreq is sampled at the edge.

## Structure
- Shared package fifo_pkg holds:
  - the state enum {IDLE, STREAM};
  - a clog2-based IDX_W helper;
  - the RATIO legality check macro, reused by a future packer on the write side.
- No sub-module is needed. The beat select is an indexed part-select in the body.

## Test plan
Bench parameters: IN_WIDTH=512, OUT_WIDTH=64.
- Reset with the FIFO non-empty (fifo_empty=0), reset_n=0 for 3 cycles:
  - fifo_rdreq=0, out_valid=0, words_done=0 throughout.
  - The first pop occurs in the cycle reset_n rises.
- One word, beat k = 64'h1000+k, out_ready=1:
  - exactly one fifo_rdreq pulse;
  - 8 consecutive beats 0x1000..0x1007, out_last on the 8th only;
  - words_done=1; then out_valid=0.
- Three back-to-back words with out_ready=1:
  - 24 consecutive valid beats with no gap;
  - fifo_rdreq pulses at relative cycles 0, 8, 16;
  - words_done=3.
- Backpressure: out_ready pattern 1,0,0,1,0,1… over one word:
  - each beat is held stable while ready=0;
  - the sequence 0x1000..0x1007 arrives exactly once each, in order.
- FIFO underrun: fifo_empty rises after word 1 and falls 5 cycles later:
  - out_valid drops after word 1's last beat;
  - word 2 beat 0 appears 1 cycle after fifo_empty falls.
- Reset mid-word after 3 beats:
  - out_valid=0 the next cycle, words_done=0;
  - the next FIFO word restarts at beat 0 with no remnant beats from the discarded word.
